// File: rtl/poly_arith_pkg.sv
// Shared types for the polynomial-arithmetic datapath: modulus, coefficient type,
// operation encoding, sequencer state encoding and the modular negation helper.
package poly_arith_pkg;

  localparam int COEFF_W = 12;

  typedef logic [COEFF_W-1:0] coeff_t;

  localparam coeff_t Q = 12'd3329;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } poly_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  // Additive inverse mod Q; zero maps to zero so the result never equals Q.
  function automatic coeff_t mod_neg(input coeff_t b);
    coeff_t r;
    if (b == 12'd0) begin
      r = 12'd0;
    end else begin
      r = Q - b;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder for operands already reduced to 0..Q-1.
module mod_add
  import poly_arith_pkg::*;
(
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t sum_o
);

  logic [COEFF_W:0] raw_s;
  coeff_t           red_s;

  // One conditional subtraction suffices because the raw sum is below 2*Q.
  always_comb begin
    raw_s = {1'b0, a_i} + {1'b0, b_i};
    red_s = raw_s[COEFF_W-1:0] - Q;
    if (raw_s >= {1'b0, Q}) begin
      sum_o = red_s;
    end else begin
      sum_o = raw_s[COEFF_W-1:0];
    end
  end

endmodule

// File: rtl/poly_addsub_seq.sv
// Streams two coefficient RAMs through one shared mod_add and writes back A+B or A-B
// mod Q; a single pass is launched by start_i and closed with a done_o pulse.
module poly_addsub_seq
  import poly_arith_pkg::*;
#(
  parameter int N_COEFFS = 256,
  parameter int ADDR_W   = $clog2(N_COEFFS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              op_i,
  input  logic              stall_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  coeff_t            a_rdata_i,
  input  coeff_t            b_rdata_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output coeff_t            wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFFS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_e        state_q, state_d;
  poly_op_e          op_q, op_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic              v2_q, v2_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  coeff_t            wr_data_q, wr_data_d;

  coeff_t            b_eff_s;
  coeff_t            sum_s;

  // Subtraction reuses the adder: feed it the modular negation of B.
  always_comb begin
    if (op_q == OP_SUB) begin
      b_eff_s = mod_neg(b_rdata_i);
    end else begin
      b_eff_s = b_rdata_i;
    end
  end

  mod_add u_mod_add (
    .a_i   (a_rdata_i),
    .b_i   (b_eff_s),
    .sum_o (sum_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stall freezes the FSM wherever it is.
  always_comb begin
    state_d = state_q;
    if (stall_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
        // With stage 1 empty, the final write (if any) retires this cycle.
        S_DRAIN: begin
          if (!v1_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; strobes are masked combinationally by the stall.
  always_comb begin
    rd_en_o   = (state_q == S_RUN) && !stall_i;
    rd_addr_o = rd_cnt_q;
    wr_en_o   = v2_q && !stall_i;
    wr_addr_o = wr_addr_q;
    wr_data_o = wr_data_q;
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE) && !stall_i;
  end

  // Datapath next-state: op capture, read counter and the two pipeline stages.
  always_comb begin
    op_d      = op_q;
    rd_cnt_d  = rd_cnt_q;
    v1_d      = v1_q;
    a1_d      = a1_q;
    v2_d      = v2_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!stall_i) begin
      if ((state_q == S_IDLE) && start_i) begin
        op_d     = poly_op_e'(op_i);
        rd_cnt_d = {ADDR_W{1'b0}};
      end else if (state_q == S_RUN) begin
        rd_cnt_d = rd_cnt_q + ADDR_ONE;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end

      v1_d = (state_q == S_RUN);
      if (state_q == S_RUN) begin
        a1_d = rd_cnt_q;
      end else begin
        a1_d = a1_q;
      end

      v2_d = v1_q;
      if (v1_q) begin
        wr_addr_d = a1_q;
        wr_data_d = sum_s;
      end else begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
      end
    end else begin
      op_d      = op_q;
      rd_cnt_d  = rd_cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= OP_ADD;
      rd_cnt_q  <= {ADDR_W{1'b0}};
      v1_q      <= 1'b0;
      a1_q      <= {ADDR_W{1'b0}};
      v2_q      <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= 12'd0;
    end else begin
      op_q      <= op_d;
      rd_cnt_q  <= rd_cnt_d;
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      v2_q      <= v2_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_poly_addsub_seq.sv
// Bench for poly_addsub_seq: RAM model, write/done monitor and a reference model
// that predicts each pass from plain modular arithmetic and a stall schedule.
module tb_poly_addsub_seq;

  localparam int N  = 256;
  localparam int AW = 8;
  localparam int QI = 3329;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          op_i;
  logic          stall_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [11:0]   a_rdata_i = 12'd0;
  logic [11:0]   b_rdata_i = 12'd0;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [11:0]   wr_data_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  poly_addsub_seq #(.N_COEFFS(N)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .stall_i   (stall_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .a_rdata_i (a_rdata_i),
    .b_rdata_i (b_rdata_i),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  int a_mem [N];
  int b_mem [N];

  // Synchronous RAM pair: data appears the cycle after a read and holds otherwise.
  always @(posedge clk_i) begin
    if (rd_en_o === 1'b1) begin
      a_rdata_i <= 12'(a_mem[rd_addr_o]);
      b_rdata_i <= 12'(b_mem[rd_addr_o]);
    end
  end

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  int  e0 = 0;
  bit  mon_on = 1'b0;
  int  mon_cyc;
  int  wq_addr [$];
  int  wq_data [$];
  int  wq_cyc  [$];
  int  dq      [$];
  int  busy_cnt = 0;
  int  stall_viol = 0;
  bit  stall_map [2048];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Monitor: cycle k of a pass is the k-th clock period after the accepting edge.
  always @(negedge clk_i) begin
    if (mon_on) begin
      mon_cyc = edge_cnt - e0 + 1;
      if (wr_en_o === 1'b1) begin
        wq_addr.push_back(int'(wr_addr_o));
        wq_data.push_back(int'(wr_data_o));
        wq_cyc.push_back(mon_cyc);
      end
      if (done_o === 1'b1) dq.push_back(mon_cyc);
      if (busy_o === 1'b1) busy_cnt++;
      if (stall_i && ((wr_en_o !== 1'b0) || (rd_en_o !== 1'b0))) stall_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ref_w(input bit op, input int a, input int b);
    if (op) return (a - b + QI) % QI;
    else    return (a + b) % QI;
  endfunction

  // The n-th cycle in which the block is not frozen by a stall.
  function automatic int nth_free(input int n);
    int seen = 0;
    for (int c = 1; c < 2048; c++) begin
      if (!stall_map[c]) begin
        seen++;
        if (seen == n) return c;
      end
    end
    return -1;
  endfunction

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    dq.delete();
    busy_cnt   = 0;
    stall_viol = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      a_mem[i] = int'($urandom_range(QI - 1, 0));
      b_mem[i] = int'($urandom_range(QI - 1, 0));
    end
  endtask

  task automatic start_pass(input bit op);
    @(posedge clk_i);
    #1;
    e0      = edge_cnt + 1;
    start_i = 1'b1;
    op_i    = op;
    stall_i = 1'b0;
    clear_mon();
    mon_on  = 1'b1;
  endtask

  task automatic run_cycles(input int first, input int last, input bit hold);
    for (int c = first; c <= last; c++) begin
      @(posedge clk_i);
      #1;
      stall_i = stall_map[c];
      start_i = hold;
      op_i    = 1'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check_pass(input string tag, input bit op);
    check({tag, "_nwr"}, wq_addr.size(), N);
    for (int k = 0; k < N && k < wq_addr.size(); k++) begin
      check({tag, "_addr"}, wq_addr[k], k);
      check({tag, "_data"}, wq_data[k], ref_w(op, a_mem[k], b_mem[k]));
      check({tag, "_wcyc"}, wq_cyc[k], nth_free(k + 3));
    end
    check({tag, "_ndone"}, dq.size(), 1);
    check({tag, "_done_cyc"}, (dq.size() > 0) ? dq[0] : -1, nth_free(N + 3));
    check({tag, "_busy_cycles"}, busy_cnt, nth_free(N + 3));
    check({tag, "_stall_strobe"}, stall_viol, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, rd_en_o, 0);
    check({tag, "_wr_en"}, wr_en_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_rd_addr"}, rd_addr_o, 0);
    check({tag, "_wr_addr"}, wr_addr_o, 0);
    check({tag, "_wr_data"}, wr_data_o, 0);
  endtask

  bit op1;
  bit op2;

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 1'b0;
    stall_i = 1'b0;
    for (int c = 0; c < 2048; c++) stall_map[c] = 1'b0;
    #2;
    check_outputs_zero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_outputs_zero("post_reset_idle");

    // Directed add: W[i] = 3i.
    for (int i = 0; i < N; i++) begin
      a_mem[i] = i;
      b_mem[i] = 2 * i;
    end
    start_pass(1'b0);
    run_cycles(1, N + 4, 1'b0);
    settle();
    check_pass("add_ramp", 1'b0);
    check("add_ramp_w255", (wq_data.size() == N) ? wq_data[N-1] : -1, 765);
    check("add_ramp_first_wcyc", (wq_cyc.size() > 0) ? wq_cyc[0] : -1, 3);
    check("add_ramp_idle_after", busy_o, 0);

    // Subtract with wrap and zero corners.
    fill_random();
    a_mem[0] = 0;    b_mem[0] = 1;
    a_mem[1] = 5;    b_mem[1] = 0;
    a_mem[2] = 1234; b_mem[2] = 1234;
    a_mem[3] = 3328; b_mem[3] = 0;
    start_pass(1'b1);
    run_cycles(1, N + 4, 1'b0);
    settle();
    check_pass("sub_rand", 1'b1);
    check("sub_0_minus_1", (wq_data.size() > 3) ? wq_data[0] : -1, 3328);
    check("sub_5_minus_0", (wq_data.size() > 3) ? wq_data[1] : -1, 5);
    check("sub_equal", (wq_data.size() > 3) ? wq_data[2] : -1, 0);

    // Add with maximal operands.
    fill_random();
    a_mem[0] = 3328; b_mem[0] = 3328;
    a_mem[1] = 0;    b_mem[1] = 0;
    start_pass(1'b0);
    run_cycles(1, N + 4, 1'b0);
    settle();
    check_pass("add_rand", 1'b0);
    check("add_max_wrap", (wq_data.size() > 1) ? wq_data[0] : -1, 3327);

    // Stalls: three cycles while read 10 is issued, one during drain.
    fill_random();
    stall_map[11]    = 1'b1;
    stall_map[12]    = 1'b1;
    stall_map[13]    = 1'b1;
    stall_map[N + 5] = 1'b1;
    op1 = 1'($urandom);
    start_pass(op1);
    run_cycles(1, N + 8, 1'b0);
    settle();
    check_pass("stall", op1);
    check("stall_done_delay", (dq.size() > 0) ? dq[0] : -1, N + 7);
    for (int c = 0; c < 2048; c++) stall_map[c] = 1'b0;

    // Start held high with op toggling, then back-to-back second pass.
    fill_random();
    op1 = 1'($urandom);
    start_pass(op1);
    run_cycles(1, N + 3, 1'b1);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op2     = ~op1;
    op_i    = op2;
    settle();
    check_pass("hold_first", op1);
    check("hold_idle_cycle", busy_o, 0);
    e0 = e0 + N + 4;
    clear_mon();
    run_cycles(1, N + 4, 1'b0);
    settle();
    check_pass("hold_second", op2);

    // Asynchronous reset in cycle 100 of a pass.
    fill_random();
    start_pass(1'b0);
    run_cycles(1, 100, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    run_cycles(101, N + 10, 1'b0);
    settle();
    check("abort_no_done", dq.size(), 0);
    check("abort_idle", busy_o, 0);

    fill_random();
    op1 = 1'($urandom);
    start_pass(op1);
    run_cycles(1, N + 4, 1'b0);
    settle();
    check_pass("after_rst", op1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
